// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache serving the IF stage
// Hits answer combinationally; misses stall the fetch and refill the whole line from word 0.
module icache_responder #(
  parameter int          LINES          = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_addr,
  input  logic        imem_read,
  output logic [31:0] imem_data,
  output logic        imem_ready,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state, state_next;
  logic [OFF_W-1:0]   cnt;
  logic               drop;
  logic [TAG_W-1:0]   line_tag;
  logic [IDX_W-1:0]   line_idx;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0]   a_off;
  logic [IDX_W-1:0]   a_idx;
  logic [TAG_W-1:0]   a_tag;
  logic               hit;
  logic               xfer;
  logic               last;
  logic               unused_addr_bits;

  assign a_off = imem_addr[2 +: OFF_W];
  assign a_idx = imem_addr[2+OFF_W +: IDX_W];
  assign a_tag = imem_addr[31 -: TAG_W];
  assign unused_addr_bits = ^imem_addr[1:0];

  assign hit  = valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign xfer = (state == REFILL) && mem_valid;
  assign last = xfer && (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      drop     <= 1'b0;
      valid    <= '0;
      line_tag <= '0;
      line_idx <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        // The lookup this cycle already used the old valid bits.
        if (invalidate)
          valid <= '0;
        if (imem_read && !hit) begin
          line_tag <= a_tag;
          line_idx <= a_idx;
          cnt      <= '0;
        end
      end else begin
        if (invalidate) begin
          valid <= '0;
          drop  <= 1'b1;
        end
        if (xfer)
          cnt <= cnt + 1'b1;
        if (last) begin
          // A fence.i arriving on the final beat must also keep the line invalid.
          if (!drop && !invalidate)
            valid[line_idx] <= 1'b1;
          drop <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer)
      data_mem[{line_idx, cnt}] <= mem_rdata;
    if (last)
      tag_mem[line_idx] <= line_tag;
  end

  always_comb begin
    state_next = state;
    imem_ready = 1'b1;
    imem_data  = NOP_INSTR;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (imem_read) begin
          if (hit) begin
            imem_data = data_mem[{a_idx, a_off}];
          end else begin
            imem_ready = 1'b0;
            state_next = REFILL;
          end
        end
      end
      REFILL: begin
        imem_ready = 1'b0;
        mem_req    = 1'b1;
        mem_addr   = {line_tag, line_idx, cnt, 2'b00};
        if (last)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - scoreboard bench for icache_responder
// Stimulus pushes expected fetch responses and refill addresses; a negedge monitor pops and compares.
module tb_icache_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        invalidate;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  icache_responder dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_read  (imem_read),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          stalls;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] addr_q[$];
  int          tests = 0;
  int          fails = 0;

  // Backing memory: word at byte address a holds 0x00100093 + a/4, answered after lat wait cycles.
  int lat = 0;
  int wait_cnt = 0;
  assign mem_valid = mem_req && (wait_cnt == lat);
  assign mem_rdata = 32'h00100093 + {2'b00, mem_addr[31:2]};

  always @(posedge clk) begin
    if (!mem_req || mem_valid)
      wait_cnt <= 0;
    else
      wait_cnt <= wait_cnt + 1;
  end

  int          stall = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall = 0;
    end else if (imem_read) begin
      if (imem_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL fetch_unexpected: served addr %h data %h with no expectation", imem_addr, imem_data);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          if (imem_data !== r.data || stall != r.stalls) begin
            fails++;
            $display("FAIL fetch %h: data %h stalls %0d, required data %h stalls %0d",
                     imem_addr, imem_data, stall, r.data, r.stalls);
          end
        end
        stall = 0;
      end else begin
        stall++;
        tests++;
        if (imem_data !== NOP) begin
          fails++;
          $display("FAIL stall_nop: imem_data %h, required %h", imem_data, NOP);
        end
      end
    end

    if (prev_wait && mem_req) begin
      tests++;
      if (mem_addr !== prev_addr) begin
        fails++;
        $display("FAIL mem_addr_stable: %h, required %h", mem_addr, prev_addr);
      end
    end
    if (mem_req && mem_valid) begin
      tests++;
      if (addr_q.size() == 0) begin
        fails++;
        $display("FAIL mem_unexpected: transfer at %h with no expectation", mem_addr);
      end else begin
        logic [31:0] ea;
        ea = addr_q.pop_front();
        if (mem_addr !== ea) begin
          fails++;
          $display("FAIL mem_addr: %h, required %h", mem_addr, ea);
        end
      end
    end
    prev_wait = mem_req && !mem_valid;
    prev_addr = mem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      addr_q.push_back(base + 32'(4 * i));
  endtask

  // Called and returns at posedge+1; holds imem_read high afterwards.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stalls);
    resp_t r;
    bit    served;
    r.data   = d;
    r.stalls = stalls;
    exp_q.push_back(r);
    imem_addr = a;
    imem_read = 1'b1;
    served = 1'b0;
    for (int i = 0; i < 64 && !served; i++) begin
      @(negedge clk);
      if (imem_ready) served = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!served) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout %h: not served, required served within 64 cycles", a);
    end
  endtask

  initial begin
    reset      = 1'b1;
    imem_addr  = '0;
    imem_read  = 1'b0;
    invalidate = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_ready", {31'b0, imem_ready}, 32'd1);
    check("reset_data", imem_data, NOP);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Cold miss, then sequential hits in the same line.
    expect_line(32'h0);
    fetch(32'h0, 32'h00100093, 5);
    fetch(32'h4, 32'h00100094, 0);
    fetch(32'h8, 32'h00100095, 0);
    fetch(32'hC, 32'h00100096, 0);

    // Conflict misses on index 0.
    expect_line(32'h100);
    fetch(32'h100, 32'h001000D3, 5);
    expect_line(32'h0);
    fetch(32'h0, 32'h00100093, 5);
    expect_line(32'h100);
    fetch(32'h104, 32'h001000D4, 5);

    // Two-cycle backing latency.
    lat = 2;
    expect_line(32'h0);
    fetch(32'h8, 32'h00100095, 13);
    fetch(32'hC, 32'h00100096, 0);
    lat = 0;

    // fence.i in IDLE drops both lines.
    expect_line(32'h40);
    fetch(32'h40, 32'h001000A3, 5);
    fetch(32'h0, 32'h00100093, 0);
    imem_read  = 1'b0;
    invalidate = 1'b1;
    @(posedge clk);
    #1;
    invalidate = 1'b0;
    expect_line(32'h0);
    fetch(32'h0, 32'h00100093, 5);
    expect_line(32'h40);
    fetch(32'h44, 32'h001000A4, 5);

    // fence.i during the second refill beat: line is refilled twice.
    expect_line(32'h200);
    expect_line(32'h200);
    fork
      fetch(32'h200, 32'h00100113, 10);
      begin
        repeat (2) @(posedge clk);
        #1;
        invalidate = 1'b1;
        @(posedge clk);
        #1;
        invalidate = 1'b0;
      end
    join
    fetch(32'h204, 32'h00100114, 0);

    // Reset in the middle of a refill.
    addr_q.push_back(32'h300);
    addr_q.push_back(32'h304);
    imem_addr = 32'h300;
    imem_read = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    imem_read = 1'b0;
    @(posedge clk);
    #1;
    check("rst_refill_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_refill_data", imem_data, NOP);
    reset = 1'b0;
    expect_line(32'h0);
    fetch(32'h0, 32'h00100093, 5);

    imem_read = 1'b0;
    repeat (2) @(posedge clk);
    check("fetch_queue_empty", 32'(exp_q.size()), 32'd0);
    check("mem_queue_empty", 32'(addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-memory responder for the IF stage. Serves imem_addr/imem_read from a small direct-mapped instruction cache.
- On a hit, returns the instruction combinationally in the same cycle, so the IF stage captures it at the next posedge.
- On a miss, deasserts imem_ready (the pipeline stalls) and refills the whole line from a backing memory over a req/valid word bus.
- Sits between if_stage and the unified memory/bus arbiter.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)
- NOP_INSTR, 32'h00000013, value driven on imem_data when no valid data is returned

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- imem_addr  in  32  fetch byte address from IF stage; bits [1:0] ignored
- imem_read  in  1  fetch request
- imem_data  out  32  instruction; valid when imem_read && imem_ready
- imem_ready  out  1  0 = fetch not served this cycle; IF stage must stall
- invalidate  in  1  fence.i pulse; clears all valid bits
- mem_req  out  1  backing-memory word request
- mem_addr  out  32  word-aligned backing address
- mem_valid  in  1  backing memory returns data; transfer on mem_req && mem_valid
- mem_rdata  in  32  backing data

Behaviour:
- Address split:
  - offset = addr[2 +: log2(WORDS_PER_LINE)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: data array LINES×WORDS_PER_LINE×32, tag array, valid bit per line.
- Reset:
  - all valid bits = 0, state = IDLE, word counter = 0, drop flag = 0
  - outputs: mem_req = 0, mem_addr = 0, imem_ready = 1 while imem_read = 0, imem_data = NOP_INSTR
- FSM states: IDLE, REFILL.
- IDLE:
  - imem_read = 0: imem_ready = 1, imem_data = NOP_INSTR.
  - imem_read = 1 and hit (valid[index] && tag match): imem_ready = 1, imem_data = line word (combinational, zero latency).
  - imem_read = 1 and miss: imem_ready = 0, imem_data = NOP_INSTR. Latch line base (tag, index) and go to REFILL with word counter = 0.
- REFILL:
  - imem_ready = 0, imem_data = NOP_INSTR, mem_req = 1.
  - mem_addr = {tag, index, counter, 2'b00}, held stable until the transfer.
  - On mem_req && mem_valid: write mem_rdata into word[counter] and increment counter.
  - Last word (counter = WORDS_PER_LINE-1) accepted: write tag; set valid unless drop flag; clear drop; go to IDLE. mem_req = 0 in the following cycle.
  - mem_valid while mem_req = 0 is ignored.
- Miss penalty with zero-wait memory (mem_valid = 1 whenever requested):
  - 1 lookup cycle + WORDS_PER_LINE refill cycles, then a hit in IDLE.
  - Default: imem_ready low for 5 cycles.
- The refill always fills from word 0, not critical-word-first.
- imem_read or imem_addr changing during REFILL does not abort the refill. On return to IDLE the current address is looked up again.
- invalidate:
  - In IDLE: all valid = 0 at the next edge. A lookup in the same cycle uses the pre-invalidate valid bits.
  - In REFILL: all valid = 0, drop flag = 1. The refill completes but the line is not marked valid, so the next fetch misses again.
- Reset during REFILL: FSM returns to IDLE, mem_req = 0 next cycle, all lines invalid.
- Only one outstanding backing-memory request at any time.
- The cache never writes to backing memory (read-only).

Test Plan:
- Reset, then imem_read = 1, addr = 0x0; memory returns word n = 0x00100093 + n, zero wait:
  - imem_ready = 0 for 5 cycles
  - mem_addr sequence = 0x0, 0x4, 0x8, 0xC
  - then imem_ready = 1, imem_data = 0x00100093
- Sequential fetch of 0x4, 0x8, 0xC after that fill: imem_ready = 1 every cycle, data = 0x00100094/95/96, mem_req stays 0.
- Conflict miss at 0x100 (same index as 0x0 for the defaults):
  - refill from 0x100; then 0x0 misses again; then 0x100 misses again
  - each miss costs 5 stall cycles
- Backing memory with 2-cycle latency:
  - mem_addr is held stable while mem_valid = 0
  - miss penalty = 1 + 4×3 = 13 stall cycles
  - data is correct afterwards
- Lines at 0x0 and 0x40 valid; pulse invalidate one cycle in IDLE: next fetch of either address misses and refills.
- invalidate pulsed during the 2nd refill word of 0x200:
  - refill completes (4 transfers), FSM returns to IDLE
  - fetch 0x200 misses again
- Reset asserted mid-refill: next cycle mem_req = 0, imem_data = NOP_INSTR; a subsequent fetch of 0x0 misses.
